// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit: funct3 size codes, error codes,
// FSM state encoding and the request legality checks used at accept time.
package mem_access_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10,
    ST_ERR  = 2'b11
  } state_t;

  // Stores only have signed-size encodings; loads reject the three unused codes.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we) return (f3 != F3_B) && (f3 != F3_H) && (f3 != F3_W);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b01:   return lo[0];
      2'b10:   return lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_lsu_align.sv
// Combinational lane logic: store byte enables and data replication, load
// extraction with sign/zero extension.
module lsu_align
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        i_f3,
  input  logic [1:0]        i_lane,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [3:0]        o_be,
  output logic [DATA_W-1:0] o_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_lane, 3'b000} +: 8];
  assign w_half = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    case (i_f3[1:0])
      2'b00: begin
        o_be    = 4'b0001 << i_lane;
        o_wdata = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        o_be    = 4'b0011 << {i_lane[1], 1'b0};
        o_wdata = {2{i_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    o_rdata = i_rdata;
    case (i_f3)
      F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_rdata = {24'h0, w_byte};
      F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
      F3_HU:   o_rdata = {16'h0, w_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store and instruction-fetch port for the multicycle core: one request at a
// time over a valid/ready memory handshake, with size/alignment checks and timeout.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_start,
  input  logic              mem_we,
  input  logic              is_fetch,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        err,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_we,
  output logic [3:0]        m_be,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [2:0]        r_f3;
  logic [DATA_W-1:0] r_wdata;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic              r_done;
  logic              r_mvalid;
  logic [DATA_W-1:0] r_rdata;
  logic [1:0]        r_err;

  logic [2:0]        w_f3_in;
  logic [3:0]        w_be;
  logic [DATA_W-1:0] w_wdata_rep;
  logic [DATA_W-1:0] w_rdata_fmt;
  logic              w_timeout;

  assign w_f3_in   = is_fetch ? F3_W : funct3;
  assign w_timeout = (MAX_WAIT != 0) && ((32'(r_cnt) + 32'd1) == 32'(MAX_WAIT));

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .i_f3    (r_f3),
    .i_lane  (r_addr[1:0]),
    .i_wdata (r_wdata),
    .i_rdata (m_rdata),
    .o_be    (w_be),
    .o_wdata (w_wdata_rep),
    .o_rdata (w_rdata_fmt)
  );

  // Request fields come straight from the latched access, so they hold while m_valid is up.
  assign m_addr  = {r_addr[ADDR_W-1:2], 2'b00};
  assign m_we    = r_mvalid & r_we;
  assign m_be    = (r_mvalid & r_we) ? w_be : 4'b0000;
  assign m_wdata = w_wdata_rep;
  assign m_valid = r_mvalid;
  assign busy    = r_busy;
  assign done    = r_done;
  assign rdata   = r_rdata;
  assign err     = r_err;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_addr   <= '0;
      r_we     <= 1'b0;
      r_f3     <= F3_W;
      r_wdata  <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_mvalid <= 1'b0;
      r_rdata  <= '0;
      r_err    <= ERR_NONE;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (mem_start) begin
            r_addr  <= addr;
            r_we    <= mem_we;
            r_f3    <= w_f3_in;
            r_wdata <= wdata;
            r_cnt   <= '0;
            if (f3_illegal(mem_we, w_f3_in)) begin
              r_state <= ST_ERR;
              r_err   <= ERR_ILLEGAL;
              r_done  <= 1'b1;
            end else if (f3_misaligned(w_f3_in, addr[1:0])) begin
              r_state <= ST_ERR;
              r_err   <= ERR_MISALIGN;
              r_done  <= 1'b1;
            end else begin
              r_state  <= ST_REQ;
              r_err    <= ERR_NONE;
              r_busy   <= 1'b1;
              r_mvalid <= 1'b1;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (m_ready) begin
            if (!r_we) r_rdata <= w_rdata_fmt;
            r_state  <= ST_DONE;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_mvalid <= 1'b0;
          end else if (w_timeout) begin
            r_state  <= ST_ERR;
            r_err    <= ERR_TIMEOUT;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_mvalid <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed accesses push expected memory
// requests and completions; a negedge monitor pops and compares them.
module tb_mem_access_unit;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_start = 1'b0;
  logic        mem_we = 1'b0;
  logic        is_fetch = 1'b0;
  logic [2:0]  funct3 = 3'b010;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        busy, done, m_valid, m_we;
  logic [31:0] rdata, m_addr, m_wdata;
  logic [1:0]  err;
  logic [3:0]  m_be;
  logic        m_ready = 1'b0;
  logic [31:0] m_rdata = '0;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  err;
  } dexp_t;

  req_t  req_q[$];
  dexp_t done_q[$];
  int    checks = 0;
  int    errors = 0;
  int    vcnt = 0;
  int    bcnt = 0;
  int    done_cnt = 0;

  mem_access_unit #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .mem_start(mem_start), .mem_we(mem_we), .is_fetch(is_fetch),
    .funct3(funct3), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
    .rdata(rdata), .err(err), .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr),
    .m_we(m_we), .m_be(m_be), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    req_t  r;
    dexp_t d;
    if (m_valid) vcnt++;
    if (busy) bcnt++;
    if (m_valid && m_ready) begin
      if (req_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_request: got addr %h, none expected", m_addr);
      end else begin
        r = req_q.pop_front();
        chk("m_addr", m_addr, r.addr);
        chk("m_we", 32'(m_we), 32'(r.we));
        chk("m_be", 32'(m_be), 32'(r.be));
        if (r.we) chk("m_wdata", m_wdata, r.wdata);
      end
    end
    if (done) begin
      done_cnt++;
      if (done_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got err %0d rdata %h, no done expected", err, rdata);
      end else begin
        d = done_q.pop_front();
        chk("rdata", rdata, d.rdata);
        chk("err", 32'(err), 32'(d.err));
        chk("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  task automatic push_req(input logic [31:0] a, input logic we, input logic [3:0] be,
                          input logic [31:0] wd);
    req_t r;
    r.addr = a; r.we = we; r.be = be; r.wdata = wd;
    req_q.push_back(r);
  endtask

  task automatic push_done(input logic [31:0] rd, input logic [1:0] e);
    dexp_t d;
    d.rdata = rd; d.err = e;
    done_q.push_back(d);
  endtask

  // dly: REQ cycles before m_ready (negative = never); exp_v: expected m_valid cycles
  task automatic access(input logic we_i, input logic fe_i, input logic [2:0] f3_i,
                        input logic [31:0] a_i, input logic [31:0] wd_i, input int dly,
                        input logic [31:0] mrd, input logic [31:0] exp_rd,
                        input logic [1:0] exp_err, input int exp_v,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd);
    int n;
    int d0;
    if (exp_v > 0 && dly >= 0) push_req(a_i & 32'hFFFF_FFFC, we_i, exp_be, exp_wd);
    push_done(exp_rd, exp_err);
    vcnt = 0; bcnt = 0; d0 = done_cnt;
    mem_start = 1'b1; mem_we = we_i; is_fetch = fe_i; funct3 = f3_i;
    addr = a_i; wdata = wd_i; m_rdata = mrd;
    @(posedge clk); #1;
    mem_start = 1'b0;
    n = 0;
    while (done_cnt == d0 && n < 20) begin
      m_ready = (n == dly);
      @(posedge clk); #1;
      n++;
    end
    m_ready = 1'b0;
    if (done_cnt == d0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles, required one", n);
    end
    chk("valid_cycles", 32'(vcnt), 32'(exp_v));
    chk("busy_cycles", 32'(bcnt), 32'(exp_v));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_we", 32'(m_we), 32'd0);
    chk("rst_m_be", 32'(m_be), 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_m_wdata", m_wdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(posedge clk); #1;

    // fetch with two wait cycles
    access(1'b0, 1'b1, 3'b111, 32'h0000_0004, 32'h0, 2, 32'h0000_0513,
           32'h0000_0513, 2'b00, 3, 4'b0000, 32'h0);
    // loads: LB, LBU, LH, LHU
    access(1'b0, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 0, 32'h8012_3456,
           32'hFFFF_FF80, 2'b00, 1, 4'b0000, 32'h0);
    access(1'b0, 1'b0, 3'b100, 32'h0000_0103, 32'h0, 0, 32'h8012_3456,
           32'h0000_0080, 2'b00, 1, 4'b0000, 32'h0);
    access(1'b0, 1'b0, 3'b001, 32'h0000_0102, 32'h0, 0, 32'h8012_3456,
           32'hFFFF_8012, 2'b00, 1, 4'b0000, 32'h0);
    // stores leave rdata alone
    access(1'b1, 1'b0, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 0, 32'h0,
           32'hFFFF_8012, 2'b00, 1, 4'b1100, 32'hABCD_ABCD);
    access(1'b1, 1'b0, 3'b000, 32'h0000_0201, 32'h0000_00EF, 1, 32'h0,
           32'hFFFF_8012, 2'b00, 2, 4'b0010, 32'hEFEF_EFEF);
    access(1'b1, 1'b0, 3'b010, 32'h0000_0204, 32'hA5A5_0F0F, 0, 32'h0,
           32'hFFFF_8012, 2'b00, 1, 4'b1111, 32'hA5A5_0F0F);
    // misaligned and illegal: no memory request
    access(1'b0, 1'b0, 3'b010, 32'h0000_0101, 32'h0, -1, 32'h0,
           32'hFFFF_8012, 2'b01, 0, 4'b0000, 32'h0);
    access(1'b0, 1'b0, 3'b101, 32'h0000_0101, 32'h0, -1, 32'h0,
           32'hFFFF_8012, 2'b01, 0, 4'b0000, 32'h0);
    access(1'b0, 1'b0, 3'b011, 32'h0000_0101, 32'h0, -1, 32'h0,
           32'hFFFF_8012, 2'b11, 0, 4'b0000, 32'h0);
    access(1'b1, 1'b0, 3'b100, 32'h0000_0200, 32'h0, -1, 32'h0,
           32'hFFFF_8012, 2'b11, 0, 4'b0000, 32'h0);
    access(1'b0, 1'b0, 3'b101, 32'h0000_0102, 32'h0, 0, 32'h8012_3456,
           32'h0000_8012, 2'b00, 1, 4'b0000, 32'h0);
    // timeout after MW cycles
    access(1'b0, 1'b0, 3'b010, 32'h0000_0300, 32'h0, -1, 32'h0,
           32'h0000_8012, 2'b10, MW, 4'b0000, 32'h0);

    // back-to-back: second start held through REQ, accepted in DONE
    push_req(32'h0000_0400, 1'b0, 4'b0000, 32'h0);
    push_done(32'hDEAD_BEEF, 2'b00);
    push_req(32'h0000_0400, 1'b0, 4'b0000, 32'h0);
    push_done(32'h0000_0012, 2'b00);
    mem_start = 1'b1; mem_we = 1'b0; is_fetch = 1'b0; funct3 = 3'b010;
    addr = 32'h0000_0400; m_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    m_ready = 1'b1; funct3 = 3'b100; addr = 32'h0000_0401;
    @(posedge clk); #1;
    m_ready = 1'b0; m_rdata = 32'hCAFE_1234;
    chk("b2b_done_state_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("b2b_valid", 32'(m_valid), 32'd1);
    mem_start = 1'b0; m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    @(posedge clk); #1;

    // reset in the middle of REQ
    d0 = done_cnt;
    mem_start = 1'b1; funct3 = 3'b010; addr = 32'h0000_0500;
    @(posedge clk); #1;
    mem_start = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("pre_rst_valid", 32'(m_valid), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("midrst_m_valid", 32'(m_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rdata", rdata, 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    repeat (5) @(posedge clk);
    #1 chk("midrst_no_done", 32'(done_cnt), 32'(d0));

    chk("req_q_drained", 32'(req_q.size()), 32'd0);
    chk("done_q_drained", 32'(done_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store and instruction-fetch memory port for the multicycle RISC-V core. It sits between the main control FSM/datapath and a memory with a valid/ready handshake.
- Accepts an access request from the FSM's memory states (fetch, MEM_READ, MEM_WRITE).
- Aligns and sizes data per funct3 and generates byte enables.
- Sign/zero-extends load data.
- Stalls the FSM via busy until the memory responds, and reports misalignment, timeout and illegal size.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width (fixed 4 byte lanes)
MAX_WAIT, 255, max cycles in REQ without m_ready before timeout; 0 disables timeout

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-low reset (rst=0 resets)
mem_start  in  1  request pulse from FSM; sampled only in IDLE or DONE
mem_we  in  1  1=store, 0=load/fetch (FSM MemWrite)
is_fetch  in  1  instruction fetch; forces word size, ignores funct3
funct3  in  3  access size/sign (LB/LH/LW/LBU/LHU, SB/SH/SW)
addr  in  ADDR_W  byte address (AdrSrc mux output)
wdata  in  DATA_W  store data (rs2)
busy  out  1  stall to FSM
done  out  1  one-cycle completion pulse (success or error)
rdata  out  DATA_W  formatted load/fetch data, held until next successful load
err  out  2  00 none, 01 misaligned, 10 timeout, 11 illegal funct3; held until next accepted start
m_valid  out  1  memory request valid
m_ready  in  1  memory accepts/completes request this cycle
m_addr  out  ADDR_W  word-aligned address {addr[31:2],2'b00}
m_we  out  1  memory write
m_be  out  4  byte enables (stores); 0000 on reads
m_wdata  out  DATA_W  lane-replicated store data
m_rdata  in  DATA_W  read data, valid in the cycle m_ready=1

Behaviour:
- Reset (rst=0 at posedge) applies regardless of state:
  - State goes to IDLE.
  - busy, done, m_valid, m_we are 0; m_be=0000.
  - m_addr, m_wdata, rdata are 0; err=00.
  - Wait counter is 0.
- Reset during REQ: m_valid drops after that edge and no done pulse is produced.
- States: IDLE, REQ, DONE, ERR.
- IDLE: busy=0. On mem_start, latch addr/we/wdata/funct3 (funct3 forced to 010 if is_fetch) and clear err. Then check in this order:
  - Illegal funct3 (loads 011/110/111; stores other than 000/001/010) → ERR, err=11.
  - Misaligned (half with addr[0]=1, word with addr[1:0]≠0) → ERR, err=01.
  - Otherwise → REQ.
- REQ: busy=1, m_valid=1. m_addr/m_we/m_be/m_wdata come from latched values and stay stable while m_valid=1.
  - m_ready=1: for loads, capture formatted m_rdata into rdata; go to DONE.
  - Otherwise the counter increments. When the counter reaches MAX_WAIT (MAX_WAIT≠0), go to ERR with err=10; m_valid is 0 from the next cycle.
- mem_start during REQ/ERR: ignored.
- DONE: done=1, busy=0, one cycle. mem_start here is accepted exactly as in IDLE (back-to-back access); otherwise go to IDLE.
- ERR: done=1, busy=0, one cycle, then IDLE. No memory request is issued for misaligned or illegal accesses.
- Latency: minimum 2 cycles from accepted start to done (REQ with immediate m_ready, then DONE).
- Store formatting, with lane = addr[1:0]:
  - SB: m_be=0001<<lane, m_wdata={4{wdata[7:0]}}.
  - SH: m_be=0011<<(2*addr[1]), m_wdata={2{wdata[15:0]}}.
  - SW: m_be=1111, m_wdata=wdata.
- Load formatting:
  - LB/LBU: byte at lane, sign/zero-extended.
  - LH/LHU: half at addr[1], sign/zero-extended.
  - LW/fetch: m_rdata unchanged.
- Stores leave rdata unchanged.

Decomposition:
- Shared definitions header (alongside the existing opcode defines): funct3 size codes (F3_B/H/W/BU/HU), err codes, state encodings.
- One natural combinational sub-module, lsu_align: byte-enable and store replication plus load extraction/extension.

Test Plan:
1. Fetch: is_fetch=1, addr=0x0000_0004, m_ready low 2 cycles then high with m_rdata=0x0000_0513 → m_valid high 3 cycles, m_addr=0x4, m_be=0000, busy=1 throughout; done pulse the cycle after ready; rdata=0x0000_0513, err=00.
2. LB at 0x103 with m_rdata=0x8012_3456, immediate ready → rdata=0x0000_0080 sign-extended = 0xFFFF_FF80; repeat with LBU → 0x0000_0080; LH at 0x102 → 0xFFFF_8012.
3. SH at 0x202, wdata=0x1234_ABCD → m_addr=0x200, m_we=1, m_be=1100, m_wdata=0xABCD_ABCD; rdata unchanged.
4. LW at 0x101 → m_valid never asserts, done pulses 1 cycle after start, err=01. funct3=011 load → err=11. Next good access clears err to 00.
5. MAX_WAIT=4, m_ready held 0 → m_valid high exactly 4 cycles then 0, done with err=10. Back-to-back: mem_start asserted in DONE → m_valid high the next cycle.
6. rst=0 asserted mid-REQ → next cycle m_valid=0, busy=0, done never pulses, rdata=0, err=00.
